prewitt_window_ctrl: RTL
========================

# prewitt_window_ctrl

Streaming controller that sequences the combinational Prewitt edge core over a raster-scan 8-bit grayscale frame. It accepts one pixel per handshake and keeps two line buffers plus a 3x3 tap window. It drives the eight neighbour taps to the edge core and registers the core's saturated result onto a valid/ready output stream. Only interior pixels produce outputs, so a frame of IMG_W x IMG_H input pixels yields (IMG_W-2)*(IMG_H-2) output pixels. The block sits between the pixel source (camera/DMA reader) and the edge-map writer.

## Interface
- IMG_W, 64, frame width in pixels (>=3)
- IMG_H, 64, frame height in lines (>=3)

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- pix_in  in  8  input pixel, raster order, row 0 column 0 first
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  controller accepts pix_in this cycle
- p0,p1,p2,p3,p5,p6,p7,p8  out  8 each  window taps to edge core (p0 top-left … p8 bottom-right, centre omitted)
- edge_in  in  8  edge core result, combinational from taps
- out_pix  out  8  edge magnitude
- out_valid  out  1  out_pix valid
- out_ready  in  1  downstream accepts out_pix
- out_last  out  1  qualifies final output of frame
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at frame completion

## Operation
- Accept = pix_valid & pix_ready. Stall = out_valid & ~out_ready.
- States:
  - IDLE: pix_ready=0. start → RUN, clear col/row counters, busy=1.
  - RUN: pix_ready = ~stall. On accept:
    - col increments and wraps at IMG_W-1 to 0, then row increments.
    - On accept of pixel (IMG_H-1, IMG_W-1) → DRAIN.
  - DRAIN: pix_ready=0. When stage 1 and stage 2 are empty, or the final out_last beat is handshaken → IDLE. done=1 for one cycle; busy drops in the same cycle.
- start outside IDLE is ignored.
- Line buffers: two IMG_W x 8 memories. lb_a holds row r-1 and lb_b holds row r-2, both indexed by col. On accept at column c:
  - Taps shift left one column. New right column: p2 ← lb_b[c], p5 ← lb_a[c], p8 ← pix_in.
  - Then lb_b[c] ← lb_a[c] and lb_a[c] ← pix_in.
  - Line buffers and taps need no reset; stale contents are masked by the window-valid rule.
- Stage 1 (window): win_valid ← accept & row>=2 & col>=2 (row/col of the accepted pixel). This window is centred at (row-1, col-1). win_last ← the same condition at the final pixel. Held during stall.
- Stage 2 (output): if ~stall, out_valid ← win_valid, out_pix ← edge_in, out_last ← win_last. Otherwise all hold.
- Widths: col counter is clog2(IMG_W) bits, row counter clog2(IMG_H) bits. No arithmetic on pixel data here; saturation to 255 happens in the edge core.

## Timing
- Reset (async assert): state=IDLE, pix_ready=0, out_valid=0, out_pix=0, out_last=0, busy=0, done=0, taps p*=0, win_valid=0, counters 0.
- Reset mid-frame aborts immediately. No done pulse. The next frame requires start.
- Latency: pixel accepted on edge k completes a window → out_valid high after edge k+1.
- out_pix, out_last and out_valid stay stable while stalled. No output is dropped or duplicated.
- Throughput: one pixel per cycle when out_ready is held high.
- Row wrap needs no bubble. The first two columns of every row produce no output.
- done asserts the cycle after the final beat (out_valid & out_last & out_ready).

## Test plan
- 4x4 frame, all pixels 77, out_ready=1 → exactly 4 outputs of 0. out_last on the 4th. done one cycle after it.
- 4x4 vertical step, columns 0–1 = 0 and columns 2–3 = 30 → 4 outputs, each 90.
- 5x5 frame, pixel (r,c) = 60·c (0,60,120,180,240) → 9 outputs, all 255 (gx=360 saturates).
- Backpressure: out_ready low for 5 cycles mid-frame → pix_ready low on the same cycles, out_pix constant, output sequence identical to the no-stall run.
- start pulsed during RUN → ignored, counters unaffected. pix_valid gaps of random length → same output sequence.
- rst_n low for 1 cycle after 7 of 16 pixels → all outputs 0 immediately, busy=0, no done. A new start frame → correct 4 outputs.

Source files
------------

// File: rtl/prewitt_window_ctrl_if.sv
// prewitt_window_ctrl_if
//
// Bundles every non-clock/reset signal of the Prewitt window controller:
// the frame start/status pair, the input pixel stream, the tap bus to the
// combinational edge core, and the output edge-magnitude stream.
//
// Modports:
//   master - the window controller itself (drives pix_ready, taps,
//            out_* stream, busy, done)
//   slave  - the surrounding system: pixel source, edge core and edge-map
//            writer (drives start, pix_in/pix_valid, edge_in, out_ready)
//
// Signals:
//   start                    one-cycle frame start pulse
//   pix_in / pix_valid       input pixel stream, raster order
//   pix_ready                controller accepts pix_in this cycle
//   p0..p3, p5..p8           3x3 window taps, centre omitted
//   edge_in                  edge core result, combinational from taps
//   out_pix / out_valid      edge magnitude stream
//   out_ready                downstream accepts out_pix
//   out_last                 marks final output of a frame
//   busy / done              frame in progress / frame-complete pulse
interface prewitt_window_ctrl_if;
  logic       start;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] p0;
  logic [7:0] p1;
  logic [7:0] p2;
  logic [7:0] p3;
  logic [7:0] p5;
  logic [7:0] p6;
  logic [7:0] p7;
  logic [7:0] p8;
  logic [7:0] edge_in;
  logic [7:0] out_pix;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    input  start, pix_in, pix_valid, edge_in, out_ready,
    output pix_ready, p0, p1, p2, p3, p5, p6, p7, p8,
    output out_pix, out_valid, out_last, busy, done
  );

  modport slave (
    output start, pix_in, pix_valid, edge_in, out_ready,
    input  pix_ready, p0, p1, p2, p3, p5, p6, p7, p8,
    input  out_pix, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/prewitt_window_ctrl.sv
// prewitt_window_ctrl
//
// Streaming controller that walks a raster-scan 8-bit grayscale frame,
// maintains two line buffers plus a 3x3 tap window, presents the eight
// neighbour taps to an external combinational Prewitt edge core, and
// registers the core's result onto a valid/ready output stream. Only
// interior pixels produce outputs: an IMG_W x IMG_H frame yields
// (IMG_W-2)*(IMG_H-2) results.
//
// Parameters:
//   IMG_W  frame width in pixels (>= 3)
//   IMG_H  frame height in lines (>= 3)
//
// Ports:
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset, aborts any frame in progress
//   bus    prewitt_window_ctrl_if.master (pixel stream in, taps out,
//          edge_in back, edge stream out, start/busy/done)
module prewitt_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prewitt_window_ctrl_if.master bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // lb_a holds the previous row, lb_b the row before that, both by column.
  logic [7:0] lb_a [IMG_W];
  logic [7:0] lb_b [IMG_W];

  // t4 is the window centre; the edge core does not need it but the
  // shift still has to carry it from the right column to the left one.
  logic [7:0] t0, t1, t2;
  logic [7:0] t3, t4, t5;
  logic [7:0] t6, t7, t8;

  logic       win_valid;
  logic       win_last;

  logic [7:0] out_pix_q;
  logic       out_valid_q;
  logic       out_last_q;
  logic       busy_q;
  logic       done_q;

  logic       stall;
  logic       pix_ready_c;
  logic       accept;
  logic       col_end;
  logic       row_end;
  logic       last_pix;
  logic       win_ok;
  logic       final_beat;
  logic       drain_empty;

  // The whole pipeline freezes while a registered result waits downstream,
  // so new pixels are refused in exactly those cycles.
  assign stall       = out_valid_q & ~bus.out_ready;
  assign pix_ready_c = (state == S_RUN) & ~stall;
  assign accept      = bus.pix_valid & pix_ready_c;

  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  assign last_pix = col_end & row_end;

  // A full 3x3 window exists once two rows and two columns precede the
  // accepted pixel; the window is centred one row up and one column left.
  assign win_ok = (row >= ROW_TWO) & (col >= COL_TWO);

  assign final_beat  = out_valid_q & out_last_q & bus.out_ready;
  assign drain_empty = ~win_valid & ~out_valid_q;

  // Frame sequencing: counters, state, busy and the done pulse. done is
  // registered so it appears the cycle after the final beat, together
  // with busy dropping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      col    <= '0;
      row    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_RUN;
            col    <= '0;
            row    <= '0;
            busy_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col_end) begin
              col <= '0;
              if (row_end) begin
                row   <= '0;
                state <= S_DRAIN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_empty | final_beat) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Line buffers carry no reset; rows are always rewritten before any
  // window that reads them is marked valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b[col] <= lb_a[col];
      lb_a[col] <= bus.pix_in;
    end
  end

  // Window shift: the left two columns move left, the new right column is
  // two-rows-up, one-row-up and the incoming pixel at the same column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t0 <= '0; t1 <= '0; t2 <= '0;
      t3 <= '0; t4 <= '0; t5 <= '0;
      t6 <= '0; t7 <= '0; t8 <= '0;
    end else if (accept) begin
      t0 <= t1; t1 <= t2; t2 <= lb_b[col];
      t3 <= t4; t4 <= t5; t5 <= lb_a[col];
      t6 <= t7; t7 <= t8; t8 <= bus.pix_in;
    end
  end

  // Stage 1 marks that the taps now hold a complete interior window; it
  // holds through a stall because the taps cannot move then either.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (!stall) begin
      win_valid <= accept & win_ok;
      win_last  <= accept & win_ok & last_pix;
    end
  end

  // Stage 2 captures the edge core result for the window flagged by
  // stage 1; everything holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= win_valid;
      out_pix_q   <= bus.edge_in;
      out_last_q  <= win_last;
    end
  end

  assign bus.pix_ready = pix_ready_c;
  assign bus.p0        = t0;
  assign bus.p1        = t1;
  assign bus.p2        = t2;
  assign bus.p3        = t3;
  assign bus.p5        = t5;
  assign bus.p6        = t6;
  assign bus.p7        = t7;
  assign bus.p8        = t8;
  assign bus.out_pix   = out_pix_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
